// File: rtl/sb_axi_mem_responder.sv
// sb_axi_mem_responder
//   AXI4 subordinate memory model standing in for host memory behind the
//   FPGA queue block's AXI manager port. Full-width INCR bursts of DW-bit
//   beats are stored in an internal word array (64-byte words, byte address
//   bits [5:0] ignored). Independent write and read engines, each with one
//   outstanding transaction.
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   s_axi_aw*           write address channel (id, addr, len, valid/ready)
//   s_axi_w*            write data channel (data, strb, last, valid/ready)
//   s_axi_b*            write response (id, resp, valid/ready)
//   s_axi_ar*           read address channel (id, addr, len, valid/ready)
//   s_axi_r*            read data channel (id, data, resp, last, valid/ready)
module sb_axi_mem_responder #(
  parameter int IDW     = 16,
  parameter int AW      = 64,
  parameter int DW      = 512,
  parameter int MEM_LG2 = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDW-1:0]    s_axi_awid,
  input  logic [AW-1:0]     s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DW-1:0]     s_axi_wdata,
  input  logic [DW/8-1:0]   s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [IDW-1:0]    s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [IDW-1:0]    s_axi_arid,
  input  logic [AW-1:0]     s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [IDW-1:0]    s_axi_rid,
  output logic [DW-1:0]     s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);
  localparam int NWORDS = 1 << MEM_LG2;
  // One extra bit above the word address so base + beat never wraps.
  localparam int IXW    = AW - 5;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [0:0] {R_IDLE, R_DATA} rstate_t;

  logic [DW-1:0] mem [NWORDS];

  function automatic logic [IXW-1:0] word_idx(input logic [AW-7:0] base,
                                              input logic [8:0]    beat);
    return {1'b0, base} + IXW'(beat);
  endfunction

  function automatic logic in_range(input logic [IXW-1:0] idx);
    return (idx >> MEM_LG2) == '0;
  endfunction

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[5:0], s_axi_araddr[5:0]};

  // Write engine
  wstate_t        wstate;
  logic [AW-7:0]  w_base;
  logic [7:0]     w_len;
  logic [8:0]     w_cnt;
  logic           w_err;
  logic [IXW-1:0] w_idx;
  logic           w_hs, w_in_len, w_commit, w_bad;

  assign w_idx    = word_idx(w_base, w_cnt);
  assign w_hs     = s_axi_wvalid && s_axi_wready;
  assign w_in_len = (w_cnt <= {1'b0, w_len});
  assign w_commit = w_hs && w_in_len && in_range(w_idx);
  // Only beats inside the announced length can be out of range; extras are just dropped.
  assign w_bad    = w_in_len && !in_range(w_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate        <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= 2'b00;
      w_base        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_err         <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            s_axi_bid     <= s_axi_awid;
            w_base        <= s_axi_awaddr[AW-1:6];
            w_len         <= s_axi_awlen;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            wstate        <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            // Saturate so a runaway burst still reads as a length mismatch.
            if (w_cnt != 9'h1FF) w_cnt <= w_cnt + 9'd1;
            if (s_axi_wlast) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err || w_bad || (w_cnt != {1'b0, w_len})) ? 2'b10 : 2'b00;
              wstate       <= W_RESP;
            end else if (w_bad) begin
              w_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Storage is never reset so contents survive a reset of the engines.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < DW/8; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx[MEM_LG2-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read engine
  rstate_t        rstate;
  logic [AW-7:0]  r_base;
  logic [7:0]     r_len;
  logic [8:0]     r_beat;
  logic [IXW-1:0] r_ld_idx;
  logic           r_ld_in;
  logic [DW-1:0]  r_ld_word;

  // Word to load at this edge: first beat on AR handshake, otherwise the next beat.
  assign r_ld_idx  = (rstate == R_IDLE) ? word_idx(s_axi_araddr[AW-1:6], 9'd0)
                                        : word_idx(r_base, r_beat + 9'd1);
  assign r_ld_in   = in_range(r_ld_idx);
  assign r_ld_word = r_ld_in ? mem[r_ld_idx[MEM_LG2-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= 2'b00;
      r_base        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            s_axi_rid     <= s_axi_arid;
            r_base        <= s_axi_araddr[AW-1:6];
            r_len         <= s_axi_arlen;
            r_beat        <= '0;
            s_axi_rdata   <= r_ld_word;
            s_axi_rresp   <= r_ld_in ? 2'b00 : 2'b10;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rvalid  <= 1'b1;
            s_axi_arready <= 1'b0;
            rstate        <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              rstate        <= R_IDLE;
            end else begin
              r_beat      <= r_beat + 9'd1;
              s_axi_rdata <= r_ld_word;
              s_axi_rresp <= r_ld_in ? 2'b00 : 2'b10;
              s_axi_rlast <= ((r_beat + 9'd1) == {1'b0, r_len});
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule
